btn_counter_display: RTL and testbench

- Debounces the board push buttons and keeps a 16-bit up/down press counter.
- Shows the counter as 4 hex digits on the time-multiplexed seven-segment display.
- Drives the LEDs with the debounced buttons, their AND/OR/XOR, and status flags.
- Single-clock block at the top of the Basys2 design; successor to the purely combinational button/LED demo.

---
 rtl/btn_counter_display.sv | 219 +++++++++++++++++++++
 tb/tb_btn_counter_display.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_counter_display.sv
// Debounced push-button up/down press counter shown on a 4-digit multiplexed hex display.
// Optional btn0 auto-repeat is compiled in with `define BTN_COUNTER_AUTOREPEAT_EN.
module btn_counter_display #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SCAN_CYCLES     = 50000,
  parameter int unsigned STEP_W          = 4
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic [7:0]       sw,
  output logic [7:0]       Led,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned ScW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  // Synchronizers carry no reset so a button held through reset is still seen as high.
  logic [N_BTN-1:0] btn_meta_q, btn_sync_q;
  logic [7:0]       sw_meta_q, sw_sync_q;

  always_ff @(posedge mclk) begin
    btn_meta_q <= btn;
    btn_sync_q <= btn_meta_q;
    sw_meta_q  <= sw;
    sw_sync_q  <= sw_meta_q;
  end

  logic [N_BTN-1:0] stable_q, stable_d, prev_q, armed_q, armed_d, press;
  logic [DbW-1:0]   db_cnt_q [N_BTN];
  logic [DbW-1:0]   db_cnt_d [N_BTN];

  // armed gates the press pulse until a settled release has been seen after reset.
  always_comb begin
    stable_d = stable_q;
    armed_d  = armed_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (btn_sync_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = btn_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
      if (!stable_q[i] && !btn_sync_q[i] && (db_cnt_q[i] == '0)) begin
        armed_d[i] = 1'b1;
      end
    end
  end

  assign press = stable_q & ~prev_q & armed_q;

  logic rep_pulse, rep_active;

`ifdef BTN_COUNTER_AUTOREPEAT_EN
  localparam int unsigned RepFirst = 64 * SCAN_CYCLES;
  localparam int unsigned RepNext  = 16 * SCAN_CYCLES;
  localparam int unsigned RepW     = $clog2(RepFirst + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_on_q, rep_on_d;

  always_comb begin
    rep_cnt_d = '0;
    rep_on_d  = 1'b0;
    rep_pulse = 1'b0;
    if (stable_q[0] && armed_q[0]) begin
      rep_on_d  = rep_on_q;
      rep_cnt_d = rep_cnt_q + 1'b1;
      if (rep_cnt_q == RepW'(rep_on_q ? RepNext : RepFirst)) begin
        rep_pulse = 1'b1;
        rep_on_d  = 1'b1;
        rep_cnt_d = RepW'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      rep_cnt_q <= '0;
      rep_on_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_on_q  <= rep_on_d;
    end
  end

  assign rep_active = rep_on_q;
`else
  assign rep_pulse  = 1'b0;
  assign rep_active = 1'b0;
`endif

  logic [15:0]       count_q, count_d;
  logic              carry_q, carry_d, borrow_q, borrow_d;
  logic [17:0]       sum;
  logic [STEP_W-1:0] step;
  logic              hold, inc, dec, clr;

  assign step = sw_sync_q[STEP_W-1:0];
  assign hold = sw_sync_q[7];
  assign inc  = (press[0] | rep_pulse) & ~hold;
  assign dec  = press[1] & ~hold;
  assign clr  = press[2];

  // Simultaneous inc/dec resolve as one signed add; bit 17 marks a borrow, bit 16 a carry.
  always_comb begin
    count_d  = count_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    sum      = {2'b00, count_q} + (inc ? {{(18 - STEP_W){1'b0}}, step} : 18'd0)
               - {17'd0, dec};
    if (clr) begin
      count_d  = '0;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
    end else if (inc || dec) begin
      count_d  = sum[15:0];
      carry_d  = carry_q | (~sum[17] & sum[16]);
      borrow_d = borrow_q | sum[17];
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    unique case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  logic [ScW-1:0] pre_q, pre_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     nibble;
  logic [7:0]     led_q, led_d;
  logic [6:0]     seg_q, seg_d;
  logic [3:0]     an_q, an_d;
  logic           dp_q, dp_d;

  // an/seg/dp are all derived from idx_d so they switch on the same edge.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == ScW'(SCAN_CYCLES - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 1'b1;
    end
    unique case (idx_d)
      2'd0:    nibble = count_q[3:0];
      2'd1:    nibble = count_q[7:4];
      2'd2:    nibble = count_q[11:8];
      default: nibble = count_q[15:12];
    endcase
    an_d  = ~(4'b0001 << idx_d);
    seg_d = glyph(nibble);
    dp_d  = ~(rep_active & (idx_d == 2'd0));
    led_d = {(count_q == 16'd0), borrow_q, carry_q, stable_q[0] ^ stable_q[1],
             stable_q[0] | stable_q[1], stable_q[0] & stable_q[1], stable_q[1], stable_q[0]};
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      stable_q <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      led_q    <= 8'h80;
      seg_q    <= 7'h40;
      an_q     <= 4'hE;
      dp_q     <= 1'b1;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      armed_q  <= armed_d;
      for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      led_q    <= led_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end

  assign Led = led_q;
  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

  logic unused_sig;
  assign unused_sig = ^{sw_sync_q, press};

endmodule

// File: tb/tb_btn_counter_display.sv
// Directed self-checking bench for btn_counter_display (DEBOUNCE_CYCLES=4, SCAN_CYCLES=3).
module tb_btn_counter_display;

  localparam int unsigned D = 4;
  localparam int unsigned S = 3;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = '0;
  logic [7:0] sw = '0;
  logic [7:0] Led;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  btn_counter_display #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(D),
    .SCAN_CYCLES    (S),
    .STEP_W         (7)
  ) dut (
    .mclk (mclk),
    .reset(reset),
    .btn  (btn),
    .sw   (sw),
    .Led  (Led),
    .seg  (seg),
    .dp   (dp),
    .an   (an)
  );

  always #5 mclk = ~mclk;

  // Active-low gfedcba glyphs for hex digits 0..F.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] model;
  logic [15:0] rd;
  logic [3:0]  prev_an;
  logic [3:0]  exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0]  exp_nib [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic        found;
  logic        dp_low_d0;
  logic        dp_low_any;

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyph[i] === s) return 4'(i);
    return 4'bxxxx;
  endfunction

  // Reads the counter back off the scanned display (one full scan plus margin).
  task automatic read_count(output logic [15:0] v);
    logic [3:0] seen;
    int k;
    seen = '0;
    v = 'x;
    for (int i = 0; i < 16 && seen != 4'hF; i++) begin
      tick(1);
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k >= 0) begin
        v[k*4 +: 4] = decode(seg);
        seen[k] = 1'b1;
      end
    end
  endtask

  task automatic check_count(input string tag, input logic [15:0] expv);
    logic [15:0] v;
    read_count(v);
    check(tag, v, expv);
  endtask

  task automatic press(input logic [3:0] m);
    btn = m;
    tick(D + 6);
    btn = '0;
    tick(D + 6);
  endtask

  // Climbs to target with btn0 presses of at most 127, tracking the expected count.
  task automatic add_to(input logic [15:0] target);
    logic [15:0] diff;
    while (model != target) begin
      diff = target - model;
      if (diff > 16'd127) diff = 16'd127;
      sw = {1'b0, diff[6:0]};
      tick(3);
      press(4'b0001);
      model = model + diff;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model = '0;
    // Reset
    reset = 1'b1;
    tick(2);
    check("reset_led", Led, 8'h80);
    check("reset_an", an, 4'b1110);
    check("reset_seg", seg, 7'b1000000);
    check("reset_dp", dp, 1'b1);
    reset = 1'b0;
    check_count("reset_count", 16'h0000);

    // Bounce: 1,0,1 then held; LEDs rise on the 7th edge after the last raw change
    sw = 8'h05;
    tick(3);
    btn = 4'b0001;
    tick(1);
    btn = 4'b0000;
    tick(1);
    btn = 4'b0001;
    tick(6);
    check("bounce_led_early", Led[4:0], 5'b00000);
    tick(1);
    check("bounce_led_rise", Led[4:0], 5'b11001);
    tick(3);
    btn = '0;
    tick(10);
    check("bounce_led_release", Led[0], 1'b0);
    check_count("bounce_count", 16'h0005);

    // Underflow and clear
    sw = 8'h00;
    tick(3);
    press(4'b0100);
    check_count("clear_count", 16'h0000);
    press(4'b0010);
    check("underflow_borrow", Led[6], 1'b1);
    check("underflow_zero", Led[7], 1'b0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1);
      if (an == 4'b1110) found = 1'b1;
    end
    check("underflow_digit0", seg, 7'b0001110);
    check_count("underflow_count", 16'hFFFF);
    press(4'b0100);
    check("clear_borrow", Led[6], 1'b0);
    check("clear_zero", Led[7], 1'b1);
    check_count("clear2_count", 16'h0000);

    // Scan order and glyph alignment at 0x1234
    model = '0;
    add_to(16'h1234);
    check_count("scan_count", 16'h1234);
    prev_an = an;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick(1);
      if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
      else prev_an = an;
    end
    check("scan_sync", found, 1'b1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("scan_an_%0d", i), an, exp_an[i/3]);
      check($sformatf("scan_seg_%0d", i), seg, glyph[exp_nib[i/3]]);
      tick(1);
    end

    // Overflow with btn0+btn1 together: 0xFFFE + 3 - 1 wraps to 0
    add_to(16'hFFFE);
    check_count("pre_overflow_count", 16'hFFFE);
    check("pre_overflow_carry", Led[5], 1'b0);
    sw = 8'h03;
    tick(3);
    btn = 4'b0011;
    tick(D + 4);
    check("both_led_logic", Led[4:0], 5'b01111);
    btn = '0;
    tick(10);
    check("overflow_carry", Led[5], 1'b1);
    check("overflow_borrow", Led[6], 1'b0);
    check("overflow_zero", Led[7], 1'b1);
    check_count("overflow_count", 16'h0000);

    // Button held through reset must not count until released and pressed again
    sw = 8'h01;
    tick(3);
    btn = 4'b0001;
    tick(12);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(15);
    check("held_reset_led0", Led[0], 1'b1);
    check("held_reset_carry", Led[5], 1'b0);
    check_count("held_reset_count", 16'h0000);
    btn = '0;
    tick(10);
    press(4'b0001);
    check_count("repress_count", 16'h0001);

    // Hold blocks btn0, btn2 still clears
    sw = 8'h81;
    tick(3);
    press(4'b0001);
    check_count("hold_count", 16'h0001);
    press(4'b0100);
    check_count("hold_clear_count", 16'h0000);

    // Long hold of btn0, step 1
    sw = 8'h01;
    tick(3);
    btn = 4'b0001;
    for (int i = 0; i < 20 && !Led[0]; i++) tick(1);
    check("long_led0", Led[0], 1'b1);
    dp_low_d0 = 1'b0;
    dp_low_any = 1'b0;
    for (int i = 0; i < 220; i++) begin
      tick(1);
      if (dp == 1'b0) dp_low_any = 1'b1;
      if (dp == 1'b0 && an == 4'b1110) dp_low_d0 = 1'b1;
    end
    btn = '0;
    tick(10);
`ifdef BTN_COUNTER_AUTOREPEAT_EN
    check_count("repeat_count", 16'h0002);
    check("repeat_dp_digit0", dp_low_d0, 1'b1);
`else
    check_count("single_press_count", 16'h0001);
    check("dp_always_off", dp_low_any, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
